alu_seq: RTL
============

// Module: alu_seq
// PURPOSE
//   Parametrised, handshaked successor to the core's combinational ALU. Accepts one
//   decoded operation, computes its result over one or more cycles and holds it until
//   the consumer takes it. Adds SUB, SLT, iterative shifts, zero/carry flags and a
//   branch next-PC result. Sits between decode and register writeback / PC update.
// PARAMETERS
//   DW   8  datapath width (rs1_data, rd_data, result); DW >= 2
//   IMW  4  PC / branch-immediate width; PC arithmetic is modulo 2^IMW
//   SW   $clog2(DW)  shift-amount width (derived; not to be overridden)
// PORTS
//   clk        in   1    clock; all state updates on rising edge
//   rst        in   1    reset; asynchronous, active-high
//   in_valid   in   1    operation presented
//   in_ready   out  1    block can accept; operation taken when in_valid && in_ready
//   op         in   4    operation code (encoding below)
//   rs1_data   in   DW   operand A
//   rd_data    in   DW   operand B; low SW bits are the shift amount for shifts
//   pc         in   IMW  PC of the branch instruction
//   b_imm      in   IMW  branch offset (unsigned, added modulo 2^IMW)
//   out_valid  out  1    result available
//   out_ready  in   1    consumer takes result when out_valid && out_ready
//   result     out  DW   operation result
//   pc_next    out  IMW  branch target / fall-through (branch ops only, else 0)
//   flag_z     out  1    result == 0
//   flag_c     out  1    carry out of ADD; borrow (A < B unsigned) for SUB; else 0
//   err        out  1    op was illegal
// BEHAVIOUR
//   Reset (async, any state, incl. mid-shift): state IDLE, in_ready=1, out_valid=0,
//     result=0, pc_next=0, flag_z=0, flag_c=0, err=0, shift counter=0. In-flight op lost.
//   Op encoding: 0000 ADD, 0001 SUB (A-B), 0010 AND, 0011 OR, 0100 XOR,
//     0101 SLT (result = {0..,A<B} unsigned), 0110 SHL, 0111 SHR (logical),
//     1000 BEQ, 1001 BLT (unsigned), 1010-1111 illegal.
//   FSM states: IDLE, SHIFT, DONE. in_ready = (state == IDLE) only.
//   IDLE: on accept of non-shift op -> compute, register outputs, -> DONE (out_valid
//     rises the cycle after accept; latency 1).
//   IDLE: on accept of SHL/SHR -> load A into result, counter = rd_data[SW-1:0];
//     if counter==0 -> DONE directly (latency 1); else -> SHIFT.
//   SHIFT: each cycle shift result by 1 bit (zero fill), decrement counter; when
//     counter reaches 0 -> DONE. Shift by n has latency 1+n cycles.
//   DONE: out_valid=1; result, pc_next, flags, err held stable while out_ready=0.
//     On out_ready -> IDLE (out_valid falls, in_ready rises next cycle).
//     Max throughput: one op per 2 cycles.
//   Arithmetic: ADD/SUB computed at DW+1 bits; result = low DW bits; flag_c = bit DW
//     for ADD, borrow for SUB. Overflow wraps silently.
//   Branch: cond = (A==B) for BEQ, (A<B) for BLT. pc_next = cond ? pc+b_imm : pc+1,
//     both modulo 2^IMW. result = {0.., cond}. flag_c=0.
//   flag_z computed from final result for all legal ops (after last shift step).
//   Illegal op: accepted normally, latency 1, result=0, pc_next=0, flag_c=0, flag_z=0, err=1.
//   err cleared on next accepted legal op.
//   in_valid while not IDLE: ignored (not accepted); producer must hold until in_ready.
//   Inputs sampled only on the accept edge; later changes do not affect the op.
// TESTING
//   ADD A=8'hF0 B=8'h20 -> 1 cycle later out_valid=1, result=8'h10, flag_c=1, flag_z=0.
//   SUB A=8'h05 B=8'h05 -> result=8'h00, flag_z=1, flag_c=0; SUB 3-5 -> 8'hFE, flag_c=1.
//   SHL A=8'h01 B=7 -> out_valid exactly 8 cycles after accept, result=8'h80;
//     SHR by 0 -> 1 cycle, result=A.
//   BEQ pc=14 b_imm=3 A==B (IMW=4) -> pc_next=1 (wrap), result=1; A!=B -> pc_next=15;
//     BLT pc=15 A>=B -> pc_next=0.
//   Backpressure: hold out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready=0,
//     new in_valid ignored; out_ready=1 -> IDLE next cycle.
//   Assert rst during SHIFT (A=8'h01, B=6, after 3 cycles) -> all outputs reset values
//     immediately, state IDLE; op 4'b1100 -> err=1, result=0; next legal ADD clears err.

Source files
------------

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq
// Description : Handshaked multi-cycle ALU with flags, iterative shifts and
//               branch next-PC computation.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_seq #(
  parameter int DW  = 8,
  parameter int IMW = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [3:0]     op,
  input  logic [DW-1:0]  rs1_data,
  input  logic [DW-1:0]  rd_data,
  input  logic [IMW-1:0] pc,
  input  logic [IMW-1:0] b_imm,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [DW-1:0]  result,
  output logic [IMW-1:0] pc_next,
  output logic           flag_z,
  output logic           flag_c,
  output logic           err
);

  localparam int SW = $clog2(DW);

  localparam logic [3:0] c_OP_ADD = 4'b0000;
  localparam logic [3:0] c_OP_SUB = 4'b0001;
  localparam logic [3:0] c_OP_AND = 4'b0010;
  localparam logic [3:0] c_OP_OR  = 4'b0011;
  localparam logic [3:0] c_OP_XOR = 4'b0100;
  localparam logic [3:0] c_OP_SLT = 4'b0101;
  localparam logic [3:0] c_OP_SHL = 4'b0110;
  localparam logic [3:0] c_OP_SHR = 4'b0111;
  localparam logic [3:0] c_OP_BEQ = 4'b1000;
  localparam logic [3:0] c_OP_BLT = 4'b1001;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t          r_state;
  logic [SW-1:0]   r_cnt;
  logic            r_is_shl;

  logic [DW:0]     w_sum;
  logic [DW:0]     w_diff;
  logic            w_lt;
  logic            w_cond;
  logic [DW-1:0]   w_res;
  logic [IMW-1:0]  w_pc;
  logic            w_c;
  logic            w_legal;
  logic            w_is_shift;
  logic [SW-1:0]   w_amt;
  logic [DW-1:0]   w_shifted;

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);

  assign w_sum     = {1'b0, rs1_data} + {1'b0, rd_data};
  assign w_diff    = {1'b0, rs1_data} - {1'b0, rd_data};
  assign w_lt      = w_diff[DW];
  assign w_amt     = rd_data[SW-1:0];
  assign w_shifted = r_is_shl ? (result << 1) : (result >> 1);

  always_comb begin
    w_res      = '0;
    w_pc       = '0;
    w_c        = 1'b0;
    w_legal    = 1'b1;
    w_is_shift = 1'b0;
    w_cond     = 1'b0;
    case (op)
      c_OP_ADD: begin w_res = w_sum[DW-1:0];  w_c = w_sum[DW]; end
      c_OP_SUB: begin w_res = w_diff[DW-1:0]; w_c = w_lt;      end
      c_OP_AND: w_res = rs1_data & rd_data;
      c_OP_OR:  w_res = rs1_data | rd_data;
      c_OP_XOR: w_res = rs1_data ^ rd_data;
      c_OP_SLT: w_res = {{(DW-1){1'b0}}, w_lt};
      c_OP_SHL, c_OP_SHR: begin
        w_res      = rs1_data;
        w_is_shift = 1'b1;
      end
      c_OP_BEQ, c_OP_BLT: begin
        w_cond = (op == c_OP_BEQ) ? (rs1_data == rd_data) : w_lt;
        w_res  = {{(DW-1){1'b0}}, w_cond};
        w_pc   = w_cond ? (pc + b_imm) : (pc + IMW'(1));
      end
      default:  w_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_is_shl <= 1'b0;
      result   <= '0;
      pc_next  <= '0;
      flag_z   <= 1'b0;
      flag_c   <= 1'b0;
      err      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            result   <= w_res;
            pc_next  <= w_pc;
            flag_c   <= w_c;
            err      <= ~w_legal;
            flag_z   <= w_legal & (w_res == '0);
            r_is_shl <= (op == c_OP_SHL);
            r_cnt    <= w_is_shift ? w_amt : '0;
            // a zero-length shift is complete on the accept edge
            if (w_is_shift && (w_amt != '0)) begin
              r_state <= S_SHIFT;
            end else begin
              r_state <= S_DONE;
            end
          end
        end
        S_SHIFT: begin
          result <= w_shifted;
          flag_z <= (w_shifted == '0);
          r_cnt  <= r_cnt - SW'(1);
          if (r_cnt == SW'(1)) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
